// File: rtl/noc_pkg.sv
// Shared NoC types: packet width, digit width, port count and encoder state encoding.
// Also used by the routing table and the display decoder.
package noc_pkg;

  localparam int PACKET_W  = 24;
  localparam int DIGIT_W   = 4;
  localparam int NUM_PORTS = 6;

  typedef logic [PACKET_W-1:0] packet_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } enc_state_t;

endpackage

// File: rtl/packet_digit_encoder_if.sv
// Packet channel from the digit encoder to the routing table.
// The encoder holds data/dest stable while valid is high, until valid & ready.
interface packet_digit_encoder_if #(
  parameter int DATA_W = noc_pkg::PACKET_W
);

  logic [DATA_W-1:0] pkt_data;
  logic [2:0]        pkt_dest;
  logic              pkt_valid;
  logic              pkt_ready;

  modport master (
    output pkt_data,
    output pkt_dest,
    output pkt_valid,
    input  pkt_ready
  );

  modport slave (
    input  pkt_data,
    input  pkt_dest,
    input  pkt_valid,
    output pkt_ready
  );

endinterface

// File: rtl/digit_shift_buffer.sv
// Nibble shift register with a saturating digit count; a new digit enters at [3:0].
// One-cycle update; shifts are dropped once full, and flush/clear take priority.
module digit_shift_buffer
  import noc_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int W      = DIGIT_W * DIGITS,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               flush,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [W-1:0]       data,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  assign full = (count == CNT_W'(DIGITS));

  always_ff @(posedge clock) begin
    if (clear || flush) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en && !full) begin
      data  <= {data[W-DIGIT_W-1:0], digit_in};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/packet_digit_encoder.sv
// Assembles hex digits into a packet and offers it to the routing table; packet valid one cycle after send.
// Holds the packet until pkt_ready; digits and sends are ignored while a packet is pending.
module packet_digit_encoder
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int DIGITS    = 6
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [DIGIT_W-1:0]     digit_in,
  input  logic                   digit_valid,
  input  logic                   send,
  input  logic [2:0]             target,
  packet_digit_encoder_if.master pkt,
  output logic [2:0]             digit_count,
  output logic                   busy,
  output logic                   err_target,
  output logic [7:0]             sent_count
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  enc_state_t       state_q, state_d;
  logic [W-1:0]     buf_data, buf_next;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full;
  logic             shift_en, flush;
  logic             send_ok, send_bad, handshake, target_ok;
  logic [W-1:0]     pkt_data_q;
  logic [2:0]       pkt_dest_q;

  digit_shift_buffer #(
    .DIGITS (DIGITS)
  ) u_buf (
    .clock    (clock),
    .clear    (clear),
    .shift_en (shift_en),
    .flush    (flush),
    .digit_in (digit_in),
    .data     (buf_data),
    .count    (buf_count),
    .full     (buf_full)
  );

  assign target_ok = ({29'd0, target} < NUM_PORTS);

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    send_ok   = 1'b0;
    send_bad  = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        shift_en = digit_valid && !buf_full;
        if (digit_valid) state_d = COLLECT;
        // A digit arriving with send makes the buffer non-empty, so the send is honoured.
        if (send && (state_q == COLLECT || digit_valid)) begin
          if (target_ok) begin
            send_ok = 1'b1;
            state_d = SEND;
          end else begin
            send_bad = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      SEND: begin
        handshake = pkt.pkt_ready;
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush    = send_bad || handshake;
  assign buf_next = shift_en ? {buf_data[W-DIGIT_W-1:0], digit_in} : buf_data;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= IDLE;
      pkt_data_q <= '0;
      pkt_dest_q <= '0;
      err_target <= 1'b0;
      sent_count <= '0;
    end else begin
      state_q <= state_d;
      if (send_ok) begin
        pkt_data_q <= buf_next;
        pkt_dest_q <= target;
        err_target <= 1'b0;
      end else if (send_bad) begin
        err_target <= 1'b1;
      end
      if (handshake) begin
        pkt_data_q <= '0;
        pkt_dest_q <= '0;
        sent_count <= sent_count + 8'd1;
      end
    end
  end

  assign pkt.pkt_data  = pkt_data_q;
  assign pkt.pkt_dest  = pkt_dest_q;
  assign pkt.pkt_valid = (state_q == SEND);
  assign busy          = (state_q == SEND);
  assign digit_count   = 3'(buf_count);

endmodule

// File: doc/packet_digit_encoder.md
PACKET_DIGIT_ENCODER -- requirements
Module: packet_digit_encoder

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 6: number of routing-table input ports addressable by pkt_dest.
REQ-002 SHALL have parameter DIGITS, default 6: number of 4-bit hex digits per packet; packet width is 4*DIGITS (24).
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port digit_in, input, 4: hex digit to append.
REQ-006 SHALL have port digit_valid, input, 1: single-cycle strobe qualifying digit_in.
REQ-007 SHALL have port send, input, 1: single-cycle request to emit the assembled packet.
REQ-008 SHALL have port target, input, 3: destination port index, sampled on an accepted send.
REQ-009 SHALL have port pkt_data, output, 24: packet payload toward the routing table.
REQ-010 SHALL have port pkt_dest, output, 3: destination port of pkt_data.
REQ-011 SHALL have port pkt_valid, output, 1: pkt_data and pkt_dest are offered.
REQ-012 SHALL have port pkt_ready, input, 1: the routing table accepts the packet this cycle.
REQ-013 SHALL have port digit_count, output, 3: number of digits currently held, 0..DIGITS.
REQ-014 SHALL have port busy, output, 1: a packet is pending handshake.
REQ-015 SHALL have port err_target, output, 1: sticky flag, last send named a nonexistent port.
REQ-016 SHALL have port sent_count, output, 8: count of completed handshakes.

Function
REQ-017 SHALL implement FSM states IDLE (count 0), COLLECT (count 1..DIGITS) and SEND (pkt_valid high).
- IDLE/COLLECT, digit_valid: shift buffer left 4, insert digit_in at [3:0], increment count.
- Digit order: the last-entered digit lands in [3:0], the first-entered in the highest filled nibble.
REQ-018 SHALL ignore digit_valid when count = DIGITS: buffer and count unchanged, no error.
REQ-019 SHALL ignore send in IDLE (count 0).
REQ-020 On send in COLLECT with target < NUM_PORTS, the module SHALL enter SEND next cycle.
- Latency: send sampled at edge N, pkt_valid high after edge N.
- pkt_data = buffer, with unfilled upper nibbles zero; pkt_dest = target.
- err_target cleared.
REQ-021 On send in COLLECT with target >= NUM_PORTS, the module SHALL set err_target, clear buffer and count, go to IDLE, and never raise pkt_valid.
REQ-022 When digit_valid and send coincide in COLLECT (or IDLE), the module SHALL accept the digit first and include it in the packet, provided count < DIGITS.
REQ-023 In SEND, the module SHALL hold pkt_valid, pkt_data and pkt_dest stable until the cycle in which pkt_valid & pkt_ready.
- digit_valid and send in SEND are ignored.
REQ-024 On handshake, the module SHALL at the next edge:
- drop pkt_valid;
- clear buffer and count;
- increment sent_count, wrapping 255 -> 0;
- return to IDLE.
- Minimum one idle cycle between packets.
REQ-025 The module SHALL drive busy = (state == SEND) and digit_count directly from registers, with no combinational path from inputs to any output.
REQ-026 The module SHALL ignore pkt_ready when pkt_valid is low.

Reset
REQ-027 While clear is sampled high, the module SHALL take priority over all inputs and drive on the next edge:
- state IDLE, buffer 0, digit_count 0;
- pkt_data 0, pkt_dest 0, pkt_valid 0, busy 0;
- err_target 0, sent_count 0.
REQ-028 On clear asserted in SEND, the module SHALL abandon the pending packet, so pkt_valid is low after that edge and no handshake is counted.

Structure
REQ-029 SHALL take the following from shared package noc_pkg, also used by the routing table and display decoder:
- constants PACKET_W=24, DIGIT_W=4, NUM_PORTS=6;
- typedef packet_t (logic [PACKET_W-1:0]);
- enum enc_state_t {IDLE, COLLECT, SEND}.
REQ-030 SHALL place the digit shift register and saturating count in one sub-module, digit_shift_buffer (ports: clock, clear, shift_en, flush, digit_in, data, count, full).

Verification
REQ-031 SHALL pass: digits 1,2,3,4,5,6 then send, target=2, pkt_ready=1 -> pkt_data=24'h123456, pkt_dest=2, pkt_valid one cycle, sent_count=1.
REQ-032 SHALL pass: digits A,B then send, target=0, pkt_ready=0 for 5 cycles then 1 -> pkt_data=24'h0000AB stable all 6 valid cycles; busy high throughout.
REQ-033 SHALL pass: 7 digits 1..7 then send -> pkt_data=24'h123456, digit_count saturates at 6.
REQ-034 SHALL pass: digit 9, then send, target=6 -> err_target=1, no pkt_valid; then digit 3, send, target=1 -> err_target=0, pkt_data=24'h000003.
REQ-035 SHALL pass: digit_valid(F) and send coincide after digits E -> pkt_data=24'h0000EF.
REQ-036 SHALL pass: clear during SEND -> pkt_valid=0 next cycle, all outputs zero; 256 handshakes -> sent_count wraps to 0.
